keycode_repeater: RTL



---
 rtl/keycode_repeater.sv | 123 ++++++++++++
 1 files changed

// File: rtl/keycode_repeater.sv
// keycode_repeater: turns a level-held keyboard keycode into one-frame step
// pulses. A press emits immediately; holding the key repeats the pulse after
// HOLD_DELAY frames and then every REPEAT_PERIOD frames. Only the four motion
// keys (A, D, S, W) are recognised; anything else counts as "no key".
module keycode_repeater #(
   parameter int HOLD_DELAY    = 20,  // 1..255
   parameter int REPEAT_PERIOD = 4    // 1..255
) (
   input  logic       frame_clk,
   input  logic       Reset_n,
   input  logic [7:0] keycode_in,
   output logic [7:0] keycode_out,
   output logic       key_held,
   output logic       repeat_active
);

   localparam logic [7:0] HOLD_LAST   = 8'(HOLD_DELAY - 1);
   localparam logic [7:0] REPEAT_LAST = 8'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cur_key_q, cur_key_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] keycode_out_q, keycode_out_d;
   logic       key_held_q, key_held_d;
   logic       repeat_active_q, repeat_active_d;
   logic       key_valid;

   // Only the four motion keys are accepted; everything else is "no key".
   always_comb begin
      key_valid = (keycode_in == 8'h04) || (keycode_in == 8'h07) ||
                  (keycode_in == 8'h16) || (keycode_in == 8'h1A);
   end

   // Next-state and registered-output logic; a pulse is emitted by loading the
   // key into keycode_out for one cycle and restarting the frame counter.
   always_comb begin
      state_d       = state_q;
      cur_key_d     = cur_key_q;
      cnt_d         = cnt_q;
      keycode_out_d = 8'h00;

      case (state_q)
         IDLE: begin
            if (key_valid) begin
               keycode_out_d = keycode_in;
               cur_key_d     = keycode_in;
               cnt_d         = 8'h00;
               state_d       = DELAY;
            end
         end
         DELAY: begin
            if (!key_valid) begin
               state_d = IDLE;
               cnt_d   = 8'h00;
            end else if (keycode_in != cur_key_q) begin
               keycode_out_d = keycode_in;
               cur_key_d     = keycode_in;
               cnt_d         = 8'h00;
            end else if (cnt_q == HOLD_LAST) begin
               keycode_out_d = cur_key_q;
               cnt_d         = 8'h00;
               state_d       = REPEAT;
            end else begin
               cnt_d = cnt_q + 8'h01;
            end
         end
         REPEAT: begin
            if (!key_valid) begin
               state_d = IDLE;
               cnt_d   = 8'h00;
            end else if (keycode_in != cur_key_q) begin
               // A different key is a fresh press: the full hold delay restarts.
               keycode_out_d = keycode_in;
               cur_key_d     = keycode_in;
               cnt_d         = 8'h00;
               state_d       = DELAY;
            end else if (cnt_q == REPEAT_LAST) begin
               keycode_out_d = cur_key_q;
               cnt_d         = 8'h00;
            end else begin
               cnt_d = cnt_q + 8'h01;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'h00;
         end
      endcase

      key_held_d      = (state_d == DELAY) || (state_d == REPEAT);
      repeat_active_d = (state_d == REPEAT);
   end

   // State and output registers; reset clears everything without a clock edge.
   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q         <= IDLE;
         cur_key_q       <= 8'h00;
         cnt_q           <= 8'h00;
         keycode_out_q   <= 8'h00;
         key_held_q      <= 1'b0;
         repeat_active_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cur_key_q       <= cur_key_d;
         cnt_q           <= cnt_d;
         keycode_out_q   <= keycode_out_d;
         key_held_q      <= key_held_d;
         repeat_active_q <= repeat_active_d;
      end
   end

   assign keycode_out   = keycode_out_q;
   assign key_held      = key_held_q;
   assign repeat_active = repeat_active_q;

endmodule
